// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Pure declarations: no logic, no latency.
// No flow control here; see wb_md_fifo and wb_port_arbiter for handshakes.
package wb_arb_pkg;

  // Register written by the exception/status path.
  localparam logic [4:0] RSTATUS_REG = 5'd30;

  // Source that owns the write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_MD,
    SRC_EXC
  } src_e;

  // One buffered multdiv result.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } md_entry_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    rd_onehot = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_md_fifo.sv
// Multdiv result FIFO with kill-by-rd and a pending-register mask.
// Latency: a push is visible at the head the next cycle; killed heads are dropped one cycle after they surface.
// Backpressure: full_o must gate push_i upstream; push while full is ignored.
//
// Ports: push_* write a new entry; pop_i retires a live head; kill_i/kill_rd_i
// invalidate every stored entry with that rd (the entry pushed in the same
// cycle is not affected); head_* expose the oldest entry; pending_o is the
// OR of one-hot(rd) over live entries.
module wb_md_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  logic [4:0]  push_rd_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
  input  logic        kill_i,
  input  logic [4:0]  kill_rd_i,
  output logic        full_o,
  output logic        head_vld_o,
  output logic [4:0]  head_rd_o,
  output logic [31:0] head_data_o,
  output logic [31:0] pending_o
);

  localparam int AW = $clog2(DEPTH);

  md_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            empty;
  logic            push_ok;
  logic            pop_eff;
  md_entry_t       head;

  assign empty       = (cnt_q == '0);
  assign full_o      = (cnt_q == (AW+1)'(DEPTH));
  assign head        = mem_q[rd_ptr_q];
  assign head_vld_o  = !empty && head.valid;
  assign head_rd_o   = head.rd;
  assign head_data_o = head.data;
  assign push_ok     = push_i && !full_o;
  // A killed entry at the head retires on its own so it never takes a
  // write-port cycle.
  assign pop_eff     = !empty && (pop_i || !head.valid);

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid) pending_o = pending_o | rd_onehot(mem_q[i].rd);
    end
    pending_o[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && mem_q[i].valid && (mem_q[i].rd == kill_rd_i)) mem_q[i].valid <= 1'b0;
      end
      if (pop_eff) begin
        mem_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      // Written last so a same-cycle kill cannot clear the new entry.
      if (push_ok) begin
        mem_q[wr_ptr_q] <= '{valid: 1'b1, rd: push_rd_i, data: push_data_i};
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      case ({push_ok, pop_eff})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the regfile write port between pipeline writeback, multdiv and the $rstatus path.
// Latency: grant in cycle N appears on rf_* in N+1; a multdiv accept reaches rf_* no earlier than N+2.
// Backpressure: writeback never stalled; md_ready = !fifo_full, exc_ready = holding register empty.
//
// Ports: clock/reset (async active-low); wb_we/wb_rd/wb_data pipeline write;
// md_valid/md_ready/md_rd/md_data multdiv results; exc_valid/exc_ready/exc_data
// status write to r30; rf_we/rf_rd/rf_data registered write port; md_pending
// mask of registers with a live buffered result; wb_hold one-cycle bubble request.
// Optional: define WB_ARB_STARVE_EN to build the starvation counter driving wb_hold.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        exc_valid,
  output logic        exc_ready,
  input  logic [31:0] exc_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic [31:0] md_pending,
  output logic        wb_hold
);

  logic        wb_req;
  logic        md_push;
  logic        fifo_full;
  logic        md_head_vld;
  logic [4:0]  md_head_rd;
  logic [31:0] md_head_data;
  src_e        grant;

  logic        exc_vld_q;
  logic [31:0] exc_data_q;
  logic        rr_exc_q;   // 0: multdiv preferred on a tie, 1: exc preferred
  logic        rf_we_q;
  logic [4:0]  rf_rd_q;
  logic [31:0] rf_data_q;

  // r0 writes are dropped at entry: a pipeline write to r0 is an idle slot.
  assign wb_req    = wb_we && (wb_rd != 5'd0);
  assign md_ready  = !fifo_full;
  assign md_push   = md_valid && md_ready && (md_rd != 5'd0);
  assign exc_ready = !exc_vld_q;

  wb_md_fifo #(.DEPTH(MD_DEPTH)) u_md_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (md_push),
    .push_rd_i   (md_rd),
    .push_data_i (md_data),
    .pop_i       (grant == SRC_MD),
    .kill_i      (grant == SRC_WB),
    .kill_rd_i   (wb_rd),
    .full_o      (fifo_full),
    .head_vld_o  (md_head_vld),
    .head_rd_o   (md_head_rd),
    .head_data_o (md_head_data),
    .pending_o   (md_pending)
  );

  always_comb begin
    grant = SRC_NONE;
    if (wb_req)                      grant = SRC_WB;
    else if (md_head_vld && exc_vld_q) grant = rr_exc_q ? SRC_EXC : SRC_MD;
    else if (md_head_vld)            grant = SRC_MD;
    else if (exc_vld_q)              grant = SRC_EXC;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exc_vld_q  <= 1'b0;
      exc_data_q <= '0;
      rr_exc_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_data_q  <= '0;
    end else begin
      if (grant == SRC_EXC) begin
        exc_vld_q <= 1'b0;
      end else if (exc_valid && exc_ready) begin
        exc_vld_q  <= 1'b1;
        exc_data_q <= exc_data;
      end
      if (grant == SRC_MD)  rr_exc_q <= 1'b1;
      if (grant == SRC_EXC) rr_exc_q <= 1'b0;
      case (grant)
        SRC_WB: begin
          rf_we_q   <= 1'b1;
          rf_rd_q   <= wb_rd;
          rf_data_q <= wb_data;
        end
        SRC_MD: begin
          rf_we_q   <= 1'b1;
          rf_rd_q   <= md_head_rd;
          rf_data_q <= md_head_data;
        end
        SRC_EXC: begin
          rf_we_q   <= 1'b1;
          rf_rd_q   <= RSTATUS_REG;
          rf_data_q <= exc_data_q;
        end
        default: rf_we_q <= 1'b0;
      endcase
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;

`ifdef WB_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;
  logic          waiting;

  assign waiting = md_head_vld || exc_vld_q;

  // Counts pipeline grants that blocked a waiting source; reaching the
  // limit requests one bubble and restarts the count.
  always_comb begin
    starve_d = '0;
    hold_d   = 1'b0;
    if ((grant == SRC_WB) && waiting) begin
      if (starve_q == CW'(STARVE_LIMIT - 1)) hold_d = 1'b1;
      else                                   starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  assign wb_hold = hold_q;
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign wb_hold = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        exc_valid = 1'b0;
  logic        exc_ready;
  logic [31:0] exc_data = '0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [31:0] md_pending;
  logic        wb_hold;

`ifdef WB_ARB_STARVE_EN
  localparam logic STARVE = 1'b1;
`else
  localparam logic STARVE = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_port_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_rd      (md_rd),
    .md_data    (md_data),
    .exc_valid  (exc_valid),
    .exc_ready  (exc_ready),
    .exc_data   (exc_data),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_data    (rf_data),
    .md_pending (md_pending),
    .wb_hold    (wb_hold)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd = rd;
    e.data = data;
    expq.push_back(e);
  endtask

  // Pipeline writes are always granted, so their expectation is queued at issue.
  task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_we = we;
    wb_rd = rd;
    wb_data = data;
    if (we && rd != 5'd0) expect_wr(rd, data);
  endtask

  task automatic drive_md(input logic v, input logic [4:0] rd, input logic [31:0] data);
    md_valid = v;
    md_rd = rd;
    md_data = data;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rf_we"}, {31'b0, rf_we}, 32'd0);
    chk({tag, "_rf_rd"}, {27'b0, rf_rd}, 32'd0);
    chk({tag, "_rf_data"}, rf_data, 32'd0);
    chk({tag, "_md_ready"}, {31'b0, md_ready}, 32'd1);
    chk({tag, "_exc_ready"}, {31'b0, exc_ready}, 32'd1);
    chk({tag, "_md_pending"}, md_pending, 32'd0);
    chk({tag, "_wb_hold"}, {31'b0, wb_hold}, 32'd0);
  endtask

  // Scoreboard monitor: every write on the port must match the queue head.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && rf_we) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write", rf_rd, rf_data);
        end else begin
          e = expq.pop_front();
          chk("wr_rd", {27'b0, rf_rd}, {27'b0, e.rd});
          chk("wr_data", rf_data, e.data);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int early_hold;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("reset");
    @(negedge clock);
    reset = 1'b1;
    step();

    // Round-robin: multdiv first after reset, then exc, then multdiv
    drive_wb(1, 5'd1, 32'h0101);
    drive_md(1, 5'd4, 32'h44);
    exc_valid = 1'b1;
    exc_data = 32'hE1;
    step();
    chk("exc_ready_loaded", {31'b0, exc_ready}, 32'd0);
    drive_wb(1, 5'd2, 32'h0202);
    drive_md(1, 5'd8, 32'h88);
    exc_valid = 1'b0;
    step();
    drive_wb(0, 5'd0, 32'h0);
    drive_md(0, 5'd0, 32'h0);
    chk("rr_pending", md_pending, 32'h0000_0110);
    expect_wr(5'd4, 32'h44);
    expect_wr(5'd30, 32'hE1);
    expect_wr(5'd8, 32'h88);
    repeat (6) step();
    chk("rr_exc_ready_free", {31'b0, exc_ready}, 32'd1);

    // Single multdiv result on an idle port
    drive_md(1, 5'd5, 32'h1234);
    expect_wr(5'd5, 32'h1234);
    step();
    drive_md(0, 5'd0, 32'h0);
    chk("md5_pending", md_pending, 32'h0000_0020);
    step();
    chk("md5_pending_clear", md_pending, 32'h0);
    repeat (3) step();

    // r0 discards: md rd=0 accepted but never written; wb to r0 is idle
    drive_md(1, 5'd0, 32'hDEAD);
    chk("r0_md_ready", {31'b0, md_ready}, 32'd1);
    step();
    chk("r0_no_pending", md_pending, 32'h0);
    drive_wb(1, 5'd0, 32'hBAD);
    drive_md(1, 5'd6, 32'h66);
    step();
    drive_md(0, 5'd0, 32'h0);
    expect_wr(5'd6, 32'h66);
    step();
    drive_wb(0, 5'd0, 32'h0);
    repeat (3) step();

    // WAW kill: buffered r3 superseded by a pipeline write to r3
    drive_wb(1, 5'd1, 32'h1111);
    drive_md(1, 5'd3, 32'hAAAA);
    step();
    drive_md(0, 5'd0, 32'h0);
    chk("kill_pending_before", md_pending, 32'h0000_0008);
    drive_wb(1, 5'd3, 32'h3333);
    step();
    drive_wb(0, 5'd0, 32'h0);
    chk("kill_pending_after", md_pending, 32'h0);
    repeat (4) step();

    // Fill the FIFO behind a busy pipeline; third result waits for a drain
    drive_wb(1, 5'd7, 32'h70);
    drive_md(1, 5'd10, 32'hA0);
    step();
    drive_wb(1, 5'd7, 32'h71);
    drive_md(1, 5'd11, 32'hB0);
    step();
    chk("full_ready_0", {31'b0, md_ready}, 32'd0);
    drive_wb(1, 5'd7, 32'h72);
    drive_md(1, 5'd12, 32'hC0);
    step();
    chk("full_ready_1", {31'b0, md_ready}, 32'd0);
    chk("full_pending", md_pending, 32'h0000_0C00);
    drive_wb(1, 5'd7, 32'h73);
    step();
    drive_wb(0, 5'd0, 32'h0);
    expect_wr(5'd10, 32'hA0);
    expect_wr(5'd11, 32'hB0);
    step();
    chk("drain_ready", {31'b0, md_ready}, 32'd1);
    step();
    drive_md(0, 5'd0, 32'h0);
    expect_wr(5'd12, 32'hC0);
    repeat (5) step();

    // Starvation: r9 buffered behind continuous pipeline writes to r7
    drive_wb(1, 5'd7, 32'h700);
    drive_md(1, 5'd9, 32'h99);
    step();
    drive_md(0, 5'd0, 32'h0);
    early_hold = 0;
    for (int k = 1; k <= 8; k++) begin
      if (wb_hold) early_hold++;
      drive_wb(1, 5'd7, 32'h700 + k);
      step();
    end
    chk("starve_no_early_hold", early_hold, 0);
    chk("starve_hold_pulse", {31'b0, wb_hold}, {31'b0, STARVE});
    drive_wb(1, 5'd7, 32'h709);
    step();
    chk("starve_hold_one_cycle", {31'b0, wb_hold}, 32'd0);
    drive_wb(0, 5'd0, 32'h0);
    expect_wr(5'd9, 32'h99);
    repeat (4) step();

    // Reset with two results buffered and status held: nothing delivered after
    drive_wb(1, 5'd7, 32'h7A);
    drive_md(1, 5'd13, 32'hD0);
    exc_valid = 1'b1;
    exc_data = 32'hE5;
    step();
    exc_valid = 1'b0;
    drive_wb(1, 5'd7, 32'h7B);
    drive_md(1, 5'd14, 32'hE0);
    step();
    drive_wb(0, 5'd0, 32'h0);
    drive_md(0, 5'd0, 32'h0);
    chk("prereset_pending", md_pending, 32'h0000_6000);
    chk("prereset_exc_ready", {31'b0, exc_ready}, 32'd0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) step();
    chk("postreset_pending", md_pending, 32'h0);
    chk("scoreboard_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
